pll_reconfig_seq: RTL
=====================

# pll_reconfig_seq

Reconfiguration sequencer that retunes the framebuffer pixel PLL at runtime, for example from 162 MHz to another video mode. It accepts a requested set of N, M and C0 divider values on a valid/ready handshake. It then acts as Avalon-MM master to the PLL reconfiguration core, which owns the PLL's 64-bit reconfig_to_pll/reconfig_from_pll buses. It writes the counter registers, triggers the reconfiguration, waits for the PLL to relock, and reports a status code.

## Interface
Parameters:
- LOCK_TIMEOUT, 65535: number of refclk cycles to wait for lock after the start write before reporting a timeout.
- C_SEL, 0: output counter index (0..17) placed in the C-register select field [22:18].

Ports:
- refclk  in  1  free-running 50 MHz management clock; the single clock of the block.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  a configuration request is present.
- cfg_ready  out  1  block is in IDLE and can accept a request.
- cfg_n_hi, cfg_n_lo  in  8 each  N counter high and low counts.
- cfg_m_hi, cfg_m_lo  in  8 each  M counter high and low counts.
- cfg_c_hi, cfg_c_lo  in  8 each  C counter high and low counts.
- done  out  1  one-cycle pulse when a request finishes.
- status  out  2  result code, valid with done and held until the next done: 0 = ok, 1 = lock timeout, 2 = bad configuration.
- mgmt_address  out  6  Avalon address.
- mgmt_writedata  out  32  Avalon write data.
- mgmt_write  out  1  Avalon write strobe.
- mgmt_waitrequest  in  1  Avalon stall.
- pll_locked  in  1  PLL locked signal, asynchronous to refclk.

## Operation
- Request capture:
  - A request is accepted on any cycle where cfg_valid and cfg_ready are both high.
  - All six count fields are registered on that edge; cfg_ready drops the following cycle.
- Field encoding, applied per counter X (N, M, C):
  - bits [7:0] = lo.
  - bits [15:8] = hi.
  - bit 16 (bypass) = 1 when hi = 0 and lo = 0.
  - bit 17 (odd) = 1 when hi ≠ lo.
  - All other bits are 0.
  - For C only, bits [22:18] = C_SEL.
- Validation:
  - A request is rejected when, for any counter, exactly one of hi and lo is zero, or |hi − lo| > 1.
  - A rejected request goes to DONE with status 2. No bus cycle is issued.
- State machine:
  - IDLE: cfg_ready = 1. On accept, go to CHECK.
  - CHECK: if invalid, go to DONE with status 2; otherwise go to WR_MODE.
  - WR_MODE: write address 0x00, data 0 (waitrequest mode).
  - WR_N: write address 0x03.
  - WR_M: write address 0x04.
  - WR_C: write address 0x05.
  - WR_START: write address 0x02, data 0. The core holds waitrequest high until reconfiguration completes.
  - WAIT_LOCK: clear the timeout counter on entry.
    - If locked_sync = 1, go to DONE with status 0.
    - Otherwise, if the counter = LOCK_TIMEOUT − 1, go to DONE with status 1.
    - Otherwise, increment the counter.
  - DONE: pulse done for one cycle, then return to IDLE.
- Avalon write rules:
  - mgmt_write, mgmt_address and mgmt_writedata are asserted on the state's first cycle.
  - They are held constant while mgmt_waitrequest = 1.
  - The write completes on the first rising edge where mgmt_write = 1 and mgmt_waitrequest = 0. The FSM advances on that edge.
  - mgmt_write is never deasserted mid-transfer.
  - mgmt_write is low in every non-WR state.
- Lock synchronisation:
  - pll_locked passes through a 2-flop synchroniser (locked_sync).
  - locked_sync is sampled only in WAIT_LOCK.
- Timeout counter: 16 bits wide; saturates and never wraps.
- Reset:
  - rst has priority over everything; it forces IDLE on the next edge.
  - This includes mid-transfer: mgmt_write drops immediately, and the partially configured PLL is left as-is.

## Timing
- Reset values:
  - cfg_ready = 1, done = 0, status = 0, mgmt_write = 0.
  - mgmt_address = 0, mgmt_writedata = 0.
  - Synchroniser flops = 0, timeout counter = 0.
- Zero-wait bus, accept at edge T:
  - CHECK at T+1.
  - Mode write at T+2, N at T+3, M at T+4, C at T+5.
  - Start write begins at T+6.
  - WAIT_LOCK begins the cycle after the start write completes.
- With locked_sync already high on entry, WAIT_LOCK takes 1 cycle: done rises at the next edge, and cfg_ready returns one cycle after done.
- A bad request produces done 2 cycles after accept (T+2).
- Lock timeout: done occurs LOCK_TIMEOUT cycles after WAIT_LOCK entry.
- cfg_valid is ignored while cfg_ready = 0; no queuing.

## Test plan
- Reset mid-stream: assert rst during WR_M with waitrequest high -> next cycle mgmt_write = 0, cfg_ready = 1, done = 0, status = 0.
- Nominal (N 3/2, M 41/40, C 3/2), zero-wait bus, pll_locked high -> address sequence 0x00, 0x03, 0x04, 0x05, 0x02 on consecutive cycles. Data:
  - N = 0x0002_0302.
  - M = 0x0002_2928.
  - C = 0x0002_0302 | (C_SEL << 18).
  - Then done with status 0.
- Waitrequest stall: hold waitrequest for 3 cycles on WR_N and 200 cycles on WR_START -> address and data stable throughout, mgmt_write continuous, no skipped or duplicated write.
- Bypass and odd encoding: request N = 0/0, C = 2/2 -> N data 0x0001_0000, C odd bit 0, done with status 0.
- Bad configuration: request M hi = 5, lo = 2 -> no mgmt_write ever asserted; done 2 cycles after accept with status 2.
- Lock timeout: LOCK_TIMEOUT = 16, pll_locked held low -> done exactly 16 cycles after WAIT_LOCK entry, status 1, cfg_ready high on the next cycle.

Source files
------------

// File: rtl/pll_reconfig_seq.sv
// Runtime retuning sequencer for the pixel PLL: takes N/M/C divider counts, writes them
// through the PLL reconfiguration core's Avalon-MM slave, starts the update and waits for relock.
module pll_reconfig_seq #(
    parameter int LOCK_TIMEOUT = 65535,
    parameter int C_SEL        = 0
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [7:0]  cfg_n_hi,
    input  logic [7:0]  cfg_n_lo,
    input  logic [7:0]  cfg_m_hi,
    input  logic [7:0]  cfg_m_lo,
    input  logic [7:0]  cfg_c_hi,
    input  logic [7:0]  cfg_c_lo,
    output logic        done,
    output logic [1:0]  status,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam logic [5:0]  ADDR_MODE  = 6'h00;
    localparam logic [5:0]  ADDR_START = 6'h02;
    localparam logic [5:0]  ADDR_N     = 6'h03;
    localparam logic [5:0]  ADDR_M     = 6'h04;
    localparam logic [5:0]  ADDR_C     = 6'h05;

    localparam logic [1:0]  STATUS_OK      = 2'd0;
    localparam logic [1:0]  STATUS_TIMEOUT = 2'd1;
    localparam logic [1:0]  STATUS_BAD     = 2'd2;

    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [4:0]  C_SEL_FIELD = 5'(C_SEL);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_WR_MODE,
        S_WR_N,
        S_WR_M,
        S_WR_C,
        S_WR_START,
        S_WAIT_LOCK,
        S_DONE
    } state_t;

    state_t      state_reg;
    logic [15:0] lock_cnt_reg;
    logic        lock_meta_reg;
    logic        locked_sync;

    // Counter index 0 = N, 1 = M, 2 = C
    logic [7:0]  hi_in  [3];
    logic [7:0]  lo_in  [3];
    logic [7:0]  hi_reg [3];
    logic [7:0]  lo_reg [3];
    logic [31:0] field_word [3];
    logic [2:0]  field_bad;

    logic accept;
    logic write_done;

    assign hi_in[0] = cfg_n_hi;
    assign lo_in[0] = cfg_n_lo;
    assign hi_in[1] = cfg_m_hi;
    assign lo_in[1] = cfg_m_lo;
    assign hi_in[2] = cfg_c_hi;
    assign lo_in[2] = cfg_c_lo;

    assign accept     = cfg_valid && cfg_ready;
    assign write_done = mgmt_write && !mgmt_waitrequest;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ctr
        localparam logic [4:0] SEL_FIELD = (gi == 2) ? C_SEL_FIELD : 5'd0;

        logic [7:0] diff;
        logic       hi_zero;
        logic       lo_zero;
        logic       bypass;
        logic       odd;

        always_ff @(posedge refclk) begin
            if (rst) begin
                hi_reg[gi] <= 8'd0;
                lo_reg[gi] <= 8'd0;
            end else if (accept) begin
                hi_reg[gi] <= hi_in[gi];
                lo_reg[gi] <= lo_in[gi];
            end
        end

        assign diff    = (hi_reg[gi] >= lo_reg[gi]) ? (hi_reg[gi] - lo_reg[gi])
                                                    : (lo_reg[gi] - hi_reg[gi]);
        assign hi_zero = (hi_reg[gi] == 8'd0);
        assign lo_zero = (lo_reg[gi] == 8'd0);
        assign bypass  = hi_zero && lo_zero;
        assign odd     = (hi_reg[gi] != lo_reg[gi]);

        // A half-zero pair or a duty split wider than one count cannot be realised.
        assign field_bad[gi]  = (hi_zero != lo_zero) || (diff > 8'd1);
        assign field_word[gi] = {9'd0, SEL_FIELD, odd, bypass, hi_reg[gi], lo_reg[gi]};
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta_reg <= 1'b0;
            locked_sync   <= 1'b0;
        end else begin
            lock_meta_reg <= pll_locked;
            locked_sync   <= lock_meta_reg;
        end
    end

    // Bus outputs are loaded on the edge that enters each write state and only change
    // again on the edge where that write is accepted, so they hold through any stall.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cfg_ready      <= 1'b1;
            done           <= 1'b0;
            status         <= STATUS_OK;
            mgmt_write     <= 1'b0;
            mgmt_address   <= 6'd0;
            mgmt_writedata <= 32'd0;
            lock_cnt_reg   <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        state_reg <= S_CHECK;
                        cfg_ready <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (|field_bad) begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                        status    <= STATUS_BAD;
                    end else begin
                        state_reg      <= S_WR_MODE;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= ADDR_MODE;
                        mgmt_writedata <= 32'd0;
                    end
                end
                S_WR_MODE: begin
                    if (write_done) begin
                        state_reg      <= S_WR_N;
                        mgmt_address   <= ADDR_N;
                        mgmt_writedata <= field_word[0];
                    end
                end
                S_WR_N: begin
                    if (write_done) begin
                        state_reg      <= S_WR_M;
                        mgmt_address   <= ADDR_M;
                        mgmt_writedata <= field_word[1];
                    end
                end
                S_WR_M: begin
                    if (write_done) begin
                        state_reg      <= S_WR_C;
                        mgmt_address   <= ADDR_C;
                        mgmt_writedata <= field_word[2];
                    end
                end
                S_WR_C: begin
                    if (write_done) begin
                        state_reg      <= S_WR_START;
                        mgmt_address   <= ADDR_START;
                        mgmt_writedata <= 32'd0;
                    end
                end
                S_WR_START: begin
                    // The core stalls this write for the whole reconfiguration.
                    if (write_done) begin
                        state_reg      <= S_WAIT_LOCK;
                        mgmt_write     <= 1'b0;
                        mgmt_address   <= 6'd0;
                        mgmt_writedata <= 32'd0;
                        lock_cnt_reg   <= 16'd0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_sync) begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                        status    <= STATUS_OK;
                    end else if (lock_cnt_reg == LOCK_LAST) begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                        status    <= STATUS_TIMEOUT;
                    end else if (lock_cnt_reg != 16'hFFFF) begin
                        lock_cnt_reg <= lock_cnt_reg + 16'd1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state_reg      <= S_IDLE;
                    cfg_ready      <= 1'b1;
                    mgmt_write     <= 1'b0;
                    mgmt_address   <= 6'd0;
                    mgmt_writedata <= 32'd0;
                end
            endcase
        end
    end

endmodule
